io_port_bank: RTL and testbench

- Port-mapped I/O block on the CPU port bus: portaddr, portval, portget, portset and portout.
- Replaces the single hard-wired display latch at machine level.
- Provides NUM_OUT writable/readable output registers and NUM_IN strobed input latches with pending/overrun status.
- Provides a registered display mux feeding ssd_driver.

---
 rtl/io_port_bank_pkg.sv | 28 ++
 rtl/io_in_latch.sv | 54 +++++
 rtl/io_port_bank.sv | 134 +++++++++++++
 tb/tb_io_port_bank.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_port_bank_pkg.sv
// Shared I/O port map for io_port_bank: default geometry, STATUS offset and
// pending/overrun bit positions, so firmware constants and the bench use one map.
package io_port_bank_pkg;

  localparam int unsigned IO_WORD_SIZE = 16;
  localparam int unsigned IO_NUM_OUT   = 4;
  localparam int unsigned IO_NUM_IN    = 2;
  localparam int unsigned IO_BASE_ADDR = 0;
  localparam int unsigned IO_SEL_BITS  = 2;

  // STATUS sits directly after the output registers and input latches.
  function automatic int unsigned io_status_offset(input int unsigned num_out,
                                                   input int unsigned num_in);
    return num_out + num_in;
  endfunction

  // Bit position of pending[ch] inside the STATUS word.
  function automatic int unsigned io_pending_bit(input int unsigned ch);
    return ch;
  endfunction

  // Bit position of overrun[ch] inside the STATUS word.
  function automatic int unsigned io_overrun_bit(input int unsigned num_in,
                                                 input int unsigned ch);
    return num_in + ch;
  endfunction

endpackage

// File: rtl/io_in_latch.sv
// One strobed input channel: data register, pending flag and overrun flag.
// Ports: clk/rst_n, strobe_i + data_i capture, clear_pending_i (latch read),
// clear_overrun_i (STATUS read); data_o/pending_o/overrun_o are the registers.
module io_in_latch #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strobe_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             clear_pending_i,
  input  logic             clear_overrun_i,
  output logic [WIDTH-1:0] data_o,
  output logic             pending_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;

  // Capture beats a same-cycle read clear; a new overrun beats a STATUS clear.
  always_comb begin
    data_d    = data_q;
    pending_d = pending_q;
    overrun_d = overrun_q & ~clear_overrun_i;
    if (strobe_i) begin
      data_d    = data_i;
      pending_d = 1'b1;
      if (pending_q && !clear_pending_i) begin
        overrun_d = 1'b1;
      end
    end else if (clear_pending_i) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/io_port_bank.sv
// Port-mapped I/O bank on the CPU port bus: NUM_OUT read/write output
// registers, NUM_IN strobed input latches, a STATUS word and a display mux.
// Ports: mclk/rst_n; portaddr/portval/portset/portget in, portout/portready
// read response; in_val/in_strobe capture; show_sel -> show_val display;
// out_vals flat view of the output registers; irq = registered OR of pending.
module io_port_bank
  import io_port_bank_pkg::*;
#(
  parameter int unsigned WORD_SIZE = IO_WORD_SIZE,
  parameter int unsigned NUM_OUT   = IO_NUM_OUT,
  parameter int unsigned NUM_IN    = IO_NUM_IN,
  parameter int unsigned BASE_ADDR = IO_BASE_ADDR,
  parameter int unsigned SEL_BITS  = IO_SEL_BITS
) (
  input  logic                        mclk,
  input  logic                        rst_n,
  input  logic [WORD_SIZE-1:0]        portaddr,
  input  logic [WORD_SIZE-1:0]        portval,
  input  logic                        portset,
  input  logic                        portget,
  output logic [WORD_SIZE-1:0]        portout,
  output logic                        portready,
  input  logic [NUM_IN*WORD_SIZE-1:0] in_val,
  input  logic [NUM_IN-1:0]           in_strobe,
  input  logic [SEL_BITS-1:0]         show_sel,
  output logic [WORD_SIZE-1:0]        show_val,
  output logic [NUM_OUT*WORD_SIZE-1:0] out_vals,
  output logic                        irq
);

  localparam int unsigned STATUS_OFF = io_status_offset(NUM_OUT, NUM_IN);
  localparam logic [WORD_SIZE-1:0] BASE_W = WORD_SIZE'(BASE_ADDR);

  if ((64'(NUM_OUT) + 64'(NUM_IN) + 64'd1) > (64'd1 << WORD_SIZE) ||
      (2 * NUM_IN) > WORD_SIZE) begin : g_bad_cfg
    $error("io_port_bank: map exceeds address space or 2*NUM_IN > WORD_SIZE");
  end

  logic [WORD_SIZE-1:0] offset;
  logic                 rd_en;
  logic [WORD_SIZE-1:0] rdata;

  logic [WORD_SIZE-1:0] out_q [NUM_OUT];
  logic [WORD_SIZE-1:0] out_d [NUM_OUT];
  logic [WORD_SIZE-1:0] portout_q, portout_d;
  logic                 portready_q, portready_d;
  logic [WORD_SIZE-1:0] show_q, show_d;
  logic                 irq_q, irq_d;

  logic [WORD_SIZE-1:0] lat_data [NUM_IN];
  logic [NUM_IN-1:0]    pending;
  logic [NUM_IN-1:0]    overrun;
  logic [NUM_IN-1:0]    clr_pend;
  logic                 clr_ovr;

  // Offset wraps at WORD_SIZE; a write in the same cycle suppresses the read.
  assign offset = portaddr - BASE_W;
  assign rd_en  = portget & ~portset;

  // Address decode, read mux and next-state for all top-level registers.
  always_comb begin
    out_d       = out_q;
    rdata       = '0;
    clr_pend    = '0;
    clr_ovr     = 1'b0;
    show_d      = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (offset == WORD_SIZE'(i)) begin
        rdata = out_q[i];
        if (portset) begin
          out_d[i] = portval;
        end
      end
      if (show_sel == SEL_BITS'(i)) begin
        show_d = out_q[i];
      end
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (offset == WORD_SIZE'(NUM_OUT + i)) begin
        rdata       = lat_data[i];
        clr_pend[i] = rd_en;
      end
    end
    if (offset == WORD_SIZE'(STATUS_OFF)) begin
      rdata   = WORD_SIZE'({overrun, pending});
      clr_ovr = rd_en;
    end
    portout_d   = rd_en ? rdata : portout_q;
    portready_d = rd_en;
    irq_d       = |pending;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        out_q[i] <= '0;
      end
      portout_q   <= '0;
      portready_q <= 1'b0;
      show_q      <= '0;
      irq_q       <= 1'b0;
    end else begin
      out_q       <= out_d;
      portout_q   <= portout_d;
      portready_q <= portready_d;
      show_q      <= show_d;
      irq_q       <= irq_d;
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    io_in_latch #(.WIDTH(WORD_SIZE)) u_latch (
      .clk             (mclk),
      .rst_n           (rst_n),
      .strobe_i        (in_strobe[g]),
      .data_i          (in_val[g*WORD_SIZE +: WORD_SIZE]),
      .clear_pending_i (clr_pend[g]),
      .clear_overrun_i (clr_ovr),
      .data_o          (lat_data[g]),
      .pending_o       (pending[g]),
      .overrun_o       (overrun[g])
    );
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_vals[g*WORD_SIZE +: WORD_SIZE] = out_q[g];
  end

  assign portout   = portout_q;
  assign portready = portready_q;
  assign show_val  = show_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a model.
module tb_io_port_bank;
  import io_port_bank_pkg::*;

  localparam int unsigned W    = 16;
  localparam int unsigned NO   = 4;
  localparam int unsigned NI   = 2;
  localparam int unsigned SB   = 3;
  localparam int unsigned BASE = 0;
  localparam int unsigned ST   = io_status_offset(NO, NI);

  logic            mclk = 1'b0;
  logic            rst_n = 1'b0;
  logic [W-1:0]    portaddr = '0;
  logic [W-1:0]    portval = '0;
  logic            portset = 1'b0;
  logic            portget = 1'b0;
  logic [W-1:0]    portout;
  logic            portready;
  logic [NI*W-1:0] in_val = '0;
  logic [NI-1:0]   in_strobe = '0;
  logic [SB-1:0]   show_sel = '0;
  logic [W-1:0]    show_val;
  logic [NO*W-1:0] out_vals;
  logic            irq;

  io_port_bank #(
    .WORD_SIZE(W), .NUM_OUT(NO), .NUM_IN(NI), .BASE_ADDR(BASE), .SEL_BITS(SB)
  ) dut (
    .mclk(mclk), .rst_n(rst_n), .portaddr(portaddr), .portval(portval),
    .portset(portset), .portget(portget), .portout(portout),
    .portready(portready), .in_val(in_val), .in_strobe(in_strobe),
    .show_sel(show_sel), .show_val(show_val), .out_vals(out_vals), .irq(irq)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integers, updated from pre-edge values.
  int unsigned m_out [NO];
  int unsigned m_lat [NI];
  bit          m_pend [NI];
  bit          m_ovr [NI];
  int unsigned e_portout = 0;
  bit          e_ready = 0;
  int unsigned e_show = 0;
  bit          e_irq = 0;

  initial begin
    for (int i = 0; i < NO; i++) m_out[i] = 0;
    for (int i = 0; i < NI; i++) begin m_lat[i] = 0; m_pend[i] = 0; m_ovr[i] = 0; end
  end

  always @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NO; i++) m_out[i] = 0;
      for (int i = 0; i < NI; i++) begin m_lat[i] = 0; m_pend[i] = 0; m_ovr[i] = 0; end
      e_portout = 0; e_ready = 0; e_show = 0; e_irq = 0;
    end else begin
      int unsigned off;
      int unsigned status;
      bit          rd;
      bit          any_p;
      off = (32'(portaddr) - BASE) & 32'hFFFF;
      rd  = portget && !portset;
      status = 0;
      any_p  = 0;
      for (int i = 0; i < NI; i++) begin
        if (m_pend[i]) status |= (32'd1 << io_pending_bit(i));
        if (m_ovr[i])  status |= (32'd1 << io_overrun_bit(NI, i));
        any_p |= m_pend[i];
      end
      e_ready = rd;
      if (rd) begin
        if (off < NO)            e_portout = m_out[off];
        else if (off < NO + NI)  e_portout = m_lat[off - NO];
        else if (off == ST)      e_portout = status;
        else                     e_portout = 0;
      end
      e_show = (32'(show_sel) < NO) ? m_out[show_sel] : 0;
      e_irq  = any_p;
      for (int i = 0; i < NI; i++) begin
        bit rd_this;
        rd_this = rd && (off == NO + i);
        if (rd && off == ST) m_ovr[i] = 0;
        if (in_strobe[i]) begin
          if (m_pend[i] && !rd_this) m_ovr[i] = 1;
          m_pend[i] = 1;
          m_lat[i]  = 32'(in_val[i*W +: W]);
        end else if (rd_this) begin
          m_pend[i] = 0;
        end
      end
      if (portset && off < NO) m_out[off] = 32'(portval);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge mclk) begin
    if (cmp_en) begin
      logic [NO*W-1:0] ev;
      for (int i = 0; i < NO; i++) ev[i*W +: W] = W'(m_out[i]);
      chk("m_portout", 64'(portout), 64'(W'(e_portout)));
      chk("m_portready", 64'(portready), 64'(e_ready));
      chk("m_show_val", 64'(show_val), 64'(W'(e_show)));
      chk("m_irq", 64'(irq), 64'(e_irq));
      chk("m_out_vals", 64'(out_vals), 64'(ev));
    end
  end

  task automatic wr(input int unsigned a, input int unsigned v);
    portaddr = W'(a); portval = W'(v); portset = 1'b1;
    @(negedge mclk);
    portset = 1'b0;
  endtask

  task automatic rd(input int unsigned a, output logic [W-1:0] d, output logic r);
    portaddr = W'(a); portget = 1'b1;
    @(negedge mclk);
    portget = 1'b0;
    d = portout; r = portready;
  endtask

  logic [W-1:0] d;
  logic         r;

  initial begin
    repeat (3) @(negedge mclk);
    cmp_en = 1'b1;
    chk("rst_portout", 64'(portout), 64'h0);
    chk("rst_portready", 64'(portready), 64'h0);
    chk("rst_out_vals", 64'(out_vals), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    rst_n = 1'b1;
    @(negedge mclk);

    // write then read
    wr(2, 'h1234);
    rd(2, d, r);
    chk("wr_rd_ready", 64'(r), 64'h1);
    chk("wr_rd_data", 64'(d), 64'h1234);
    @(negedge mclk);
    chk("ready_pulse_end", 64'(portready), 64'h0);
    chk("out_vals_slice2", 64'(out_vals[47:32]), 64'h1234);

    // display mux latency and out-of-range select
    show_sel = 3'd1;
    wr(1, 'hBEEF);
    chk("show_one_edge", 64'(show_val), 64'h0);
    @(negedge mclk);
    chk("show_two_edges", 64'(show_val), 64'hBEEF);
    show_sel = 3'd5;
    @(negedge mclk);
    chk("show_oob", 64'(show_val), 64'h0);

    // input capture
    in_val[15:0] = 16'h00AA; in_strobe = 2'b01;
    @(negedge mclk);
    in_strobe = 2'b00;
    chk("irq_lag", 64'(irq), 64'h0);
    @(negedge mclk);
    chk("irq_set", 64'(irq), 64'h1);
    rd(ST, d, r); chk("status_cap", 64'(d), 64'h0001);
    rd(4, d, r);  chk("ch0_data", 64'(d), 64'h00AA);
    rd(ST, d, r); chk("status_clr", 64'(d), 64'h0000);
    chk("irq_fall", 64'(irq), 64'h0);

    // overrun on ch1
    in_val[31:16] = 16'h0011; in_strobe = 2'b10;
    @(negedge mclk);
    in_val[31:16] = 16'h0022;
    @(negedge mclk);
    in_strobe = 2'b00;
    rd(ST, d, r); chk("ovr_status1", 64'(d), 64'h000A);
    rd(ST, d, r); chk("ovr_status2", 64'(d), 64'h0002);
    rd(5, d, r);  chk("ovr_ch1", 64'(d), 64'h0022);
    rd(ST, d, r); chk("ovr_status3", 64'(d), 64'h0000);

    // set+get collision
    portaddr = 16'h0000; portval = 16'h0007; portset = 1'b1; portget = 1'b1;
    @(negedge mclk);
    portset = 1'b0; portget = 1'b0;
    chk("coll_no_ready", 64'(portready), 64'h0);
    chk("coll_reg0", 64'(out_vals[15:0]), 64'h0007);

    // capture and read-clear of the same channel
    in_val[15:0] = 16'h0033; in_strobe = 2'b01;
    @(negedge mclk);
    in_val[15:0] = 16'h0055;
    rd(4, d, r);
    in_strobe = 2'b00;
    chk("cr_old_data", 64'(d), 64'h0033);
    rd(ST, d, r); chk("cr_status", 64'(d), 64'h0001);
    rd(4, d, r);  chk("cr_new_data", 64'(d), 64'h0055);

    // unmapped and read-only writes
    rd('hFF, d, r);
    chk("unmap_ready", 64'(r), 64'h1);
    chk("unmap_data", 64'(d), 64'h0);
    wr('hFF, 'hFFFF);
    wr(4, 'hDEAD);
    wr(ST, 'hFFFF);
    chk("unmap_wr", 64'(out_vals), 64'h0000_1234_BEEF_0007);
    rd(ST, d, r); chk("status_ro", 64'(d), 64'h0000);

    // reset in the middle of a read
    show_sel = 3'd2; in_val[31:16] = 16'h0099; in_strobe = 2'b10;
    @(negedge mclk);
    in_strobe = 2'b00;
    @(negedge mclk);
    portaddr = 16'h0002; portget = 1'b1;
    @(posedge mclk);
    #1;
    chk("pre_rst_ready", 64'(portready), 64'h1);
    chk("pre_rst_irq", 64'(irq), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_portout", 64'(portout), 64'h0);
    chk("arst_portready", 64'(portready), 64'h0);
    chk("arst_show_val", 64'(show_val), 64'h0);
    chk("arst_irq", 64'(irq), 64'h0);
    chk("arst_out_vals", 64'(out_vals), 64'h0);
    portget = 1'b0;
    @(negedge mclk);
    @(negedge mclk);
    rst_n = 1'b1;
    @(negedge mclk);
    chk("post_rst_ready", 64'(portready), 64'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      portaddr  = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 7));
      portval   = W'($urandom);
      portset   = ($urandom_range(0, 3) == 0);
      portget   = ($urandom_range(0, 2) == 0);
      in_strobe = NI'($urandom_range(0, 3));
      in_val    = (NI*W)'($urandom);
      show_sel  = SB'($urandom_range(0, 7));
      @(negedge mclk);
    end
    portset = 1'b0; portget = 1'b0; in_strobe = '0;
    repeat (3) @(negedge mclk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
